// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Imported by the top and the 4-bit slice.
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/nibble_serial_adder_add4_slice.sv
// Combinational 4-bit ripple-carry slice built from full-adder cells.
// Shared by every nibble of a serial add.
module add4_slice
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s4,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    logic p;
    assign p        = a4[i] ^ b4[i];
    assign s4[i]    = p ^ c[i];
    assign c[i+1]   = (a4[i] & b4[i]) | (p & c[i]);
  end

  assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one nibble per cycle through a single slice,
// with a registered carry and valid/ready on both sides.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  nsa_state_t state;

  logic [IW-1:0]       idx;
  logic                carry;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic [NIBBLE_W-1:0] a4;
  logic [NIBBLE_W-1:0] b4;
  logic [NIBBLE_W-1:0] s4;
  logic                co;
  logic                last;
  logic                ovf_nx;

  assign a4 = a_r[idx*NIBBLE_W +: NIBBLE_W];
  assign b4 = b_r[idx*NIBBLE_W +: NIBBLE_W];

  add4_slice u_slice (
    .a4 (a4),
    .b4 (b4),
    .ci (carry),
    .s4 (s4),
    .co (co)
  );

  assign last = (idx == IW'(NIB - 1));

  // On the last nibble the slice MSB is the result sign bit.
  assign ovf_nx = (a_r[WIDTH-1] == b_r[WIDTH-1])
               && (s4[NIBBLE_W-1] != a_r[WIDTH-1]);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= s4;
          carry <= co;
          if (last) begin
            cout  <= co;
            ovf   <= ovf_nx;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16).
// Directed vectors; a negedge monitor pops and checks each result.
module tb_nibble_serial_adder;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
        chk("ovf", 32'(ovf), 32'(e.o));
      end
    end
  end

  task automatic issue(logic [15:0] av, logic [15:0] bv, logic ci,
                       logic [15:0] es, logic ec, logic eo);
    exp_t e;
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    a = av;
    b = bv;
    cin = ci;
    in_valid = 1'b1;
    e.s = es;
    e.c = ec;
    e.o = eo;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'd4);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic op(logic [15:0] av, logic [15:0] bv, logic ci,
                    logic [15:0] es, logic ec, logic eo);
    issue(av, bv, ci, es, ec, eo);
    wait_valid();
    drain();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Backpressure: result must hold for 5 stalled cycles.
    out_ready = 1'b0;
    issue(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h0001);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // New operands offered during RUN are ignored.
    issue(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = 16'hAAAA;
    b = 16'h5555;
    cin = 1'b1;
    chk("run_in_ready", 32'(in_ready), 32'd0);
    wait_valid();
    in_valid = 1'b0;
    drain();
    op(16'h2222, 16'h3333, 1'b1, 16'h5556, 1'b0, 1'b0);

    // Reset in the second RUN cycle aborts the op.
    issue(16'h1111, 16'h1111, 1'b0, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    q.delete();
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    op(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
